spi_sequencer: RTL

Controller in front of the HDP serial register port engine.
- After reset, replays a fixed register-initialisation table as SPI writes.
- Then shares the SPI engine between two requesters (req0: display logic, read/write; req1: status poller, read/write) using round-robin arbitration.
- Owns every begin/address/data input of the SPI engine. Exactly one transaction is in flight at any time.

---
 rtl/spi_seq_pkg.sv | 22 ++
 rtl/spi_init_rom.sv | 18 +
 rtl/spi_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared widths, FSM encoding and init-table contents for spi_sequencer.
// SPI_SEQ_VERIFY_EN adds the readback-verify states to the encoding.
package spi_seq_pkg;
  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned INIT_TABLE_N = 4;
  localparam logic [INIT_TABLE_N-1:0][7:0] INIT_ADDR = {8'h10, 8'h02, 8'h01, 8'h00};
  localparam logic [INIT_TABLE_N-1:0][7:0] INIT_DATA = {8'h05, 8'h3C, 8'h80, 8'h01};
  typedef enum logic [3:0] {
    S_DRAIN,
    S_INIT_ISSUE,
    S_INIT_WAIT,
`ifdef SPI_SEQ_VERIFY_EN
    S_VERIFY_ISSUE,
    S_VERIFY_WAIT,
`endif
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;
endpackage

// File: rtl/spi_init_rom.sv
// spi_init_rom: combinational init-table lookup; indices past the table read as zero.
module spi_init_rom
  import spi_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [3:0]        idx_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);
  logic hit;
  assign hit = idx_i[3:2] == 2'b00;
  always_comb begin
    addr_o = hit ? ADDR_W'(INIT_ADDR[idx_i[1:0]]) : '0;
    data_o = hit ? DATA_W'(INIT_DATA[idx_i[1:0]]) : '0;
  end
endmodule

// File: rtl/spi_sequencer.sv
// spi_sequencer: replays the init table, then round-robins two requesters onto one SPI engine.
// Define SPI_SEQ_VERIFY_EN to read back each init write and flag mismatches on o_initError.
module spi_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned INIT_COUNT = 4,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W
) (
  input  logic              i_clock,
  input  logic              i_reset,
  output logic              o_spiTxBegin,
  output logic [ADDR_W-1:0] o_spiTxAddress,
  output logic [DATA_W-1:0] o_spiTxData,
  input  logic              i_spiTxBusy,
  input  logic              i_spiTxDone,
  output logic              o_spiRxBegin,
  output logic [ADDR_W-1:0] o_spiRxAddress,
  input  logic [DATA_W-1:0] i_spiRxData,
  input  logic              i_spiRxBusy,
  input  logic              i_spiRxDone,
  input  logic              i_req0Valid,
  input  logic              i_req0Write,
  input  logic [ADDR_W-1:0] i_req0Address,
  input  logic [DATA_W-1:0] i_req0Data,
  output logic              o_req0Ready,
  output logic              o_rsp0Valid,
  output logic [DATA_W-1:0] o_rsp0Data,
  input  logic              i_req1Valid,
  input  logic              i_req1Write,
  input  logic [ADDR_W-1:0] i_req1Address,
  input  logic [DATA_W-1:0] i_req1Data,
  output logic              o_req1Ready,
  output logic              o_rsp1Valid,
  output logic [DATA_W-1:0] o_rsp1Data,
`ifdef SPI_SEQ_VERIFY_EN
  output logic              o_initError,
`endif
  output logic              o_initDone
);
  state_e            state_q;
  logic [3:0]        idx_q, rom_idx;
  logic [ADDR_W-1:0] rom_addr, addr_q;
  logic [DATA_W-1:0] rom_data, data_q, rdata_q;
  logic              write_q, gnt_q, last_q, done_q;
  logic              busy, any, pick, last_entry, init_step;
  spi_init_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
    .idx_i (rom_idx),
    .addr_o(rom_addr),
    .data_o(rom_data)
  );
  assign busy       = i_spiTxBusy | i_spiRxBusy;
  assign any        = i_req0Valid | i_req1Valid;
  assign pick       = (i_req0Valid & i_req1Valid) ? ~last_q : ~i_req0Valid;
  assign rom_idx    = (state_q == S_DRAIN) ? idx_q : idx_q + 4'd1;
  assign last_entry = idx_q == 4'(INIT_COUNT - 1);
  assign o_req0Ready = state_q == S_IDLE && any && !pick;
  assign o_req1Ready = state_q == S_IDLE && any && pick;
  assign o_rsp0Valid = state_q == S_RESP && !gnt_q;
  assign o_rsp1Valid = state_q == S_RESP && gnt_q;
  assign o_rsp0Data  = o_rsp0Valid ? rdata_q : '0;
  assign o_rsp1Data  = o_rsp1Valid ? rdata_q : '0;
  assign o_spiTxAddress = addr_q;
  assign o_spiRxAddress = addr_q;
  assign o_spiTxData    = data_q;
  assign o_initDone     = done_q;
  assign o_spiTxBegin   = !busy && (state_q == S_INIT_ISSUE || (state_q == S_ISSUE && write_q));
`ifdef SPI_SEQ_VERIFY_EN
  logic err_q;
  assign o_initError  = err_q;
  assign o_spiRxBegin = !busy && (state_q == S_VERIFY_ISSUE || (state_q == S_ISSUE && !write_q));
  assign init_step    = state_q == S_VERIFY_WAIT && i_spiRxDone;
`else
  assign o_spiRxBegin = !busy && state_q == S_ISSUE && !write_q;
  assign init_step    = state_q == S_INIT_WAIT && i_spiTxDone;
`endif
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_DRAIN;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef SPI_SEQ_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_DRAIN: if (!busy) begin
          addr_q  <= rom_addr;
          data_q  <= rom_data;
          state_q <= S_INIT_ISSUE;
        end
        S_INIT_ISSUE: if (!busy) state_q <= S_INIT_WAIT;
`ifdef SPI_SEQ_VERIFY_EN
        S_INIT_WAIT: if (i_spiTxDone) state_q <= S_VERIFY_ISSUE;
        S_VERIFY_ISSUE: if (!busy) state_q <= S_VERIFY_WAIT;
        S_VERIFY_WAIT: if (i_spiRxDone && i_spiRxData != data_q) err_q <= 1'b1;
`endif
        S_IDLE: if (any) begin
          gnt_q   <= pick;
          last_q  <= pick;
          write_q <= pick ? i_req1Write : i_req0Write;
          addr_q  <= pick ? i_req1Address : i_req0Address;
          data_q  <= pick ? i_req1Data : i_req0Data;
          state_q <= S_ISSUE;
        end
        S_ISSUE: if (!busy) state_q <= S_WAIT;
        S_WAIT: if (write_q ? i_spiTxDone : i_spiRxDone) begin
          rdata_q <= write_q ? '0 : i_spiRxData;
          state_q <= S_RESP;
        end
        S_RESP: state_q <= S_IDLE;
        default: ;
      endcase
      // Completion of an init entry (write, or its readback) advances or finishes the table.
      if (init_step) begin
        if (last_entry) begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end else begin
          idx_q   <= idx_q + 4'd1;
          addr_q  <= rom_addr;
          data_q  <= rom_data;
          state_q <= S_INIT_ISSUE;
        end
      end
    end
  end
endmodule
